// File: rtl/router_1x3.sv
// rtl/router_1x3.sv - registered 1-to-3 byte demultiplexing router
//
// Each rising clock edge, data_in is steered to the output port chosen by
// control. That port's valid flag is set, and the other two ports are
// cleared to zero with their valid flags low. control = 2'b11 is an idle
// code that clears every port. All outputs come straight from flops, so
// the latency is one cycle and there is no combinational path from the
// inputs to the outputs.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high; clears all outputs
//   data_in     in   WIDTH  word to route
//   control     in   2      00 -> port 1, 01 -> port 2, 10 -> port 3, 11 -> none
//   data_out1   out  WIDTH  port 1 data (zero when not selected)
//   data_out2   out  WIDTH  port 2 data (zero when not selected)
//   data_out3   out  WIDTH  port 3 data (zero when not selected)
//   valid_out1  out  1      port 1 holds routed data this cycle
//   valid_out2  out  1      port 2 holds routed data this cycle
//   valid_out3  out  1      port 3 holds routed data this cycle

module router_1x3 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3,
    output logic             valid_out1,
    output logic             valid_out2,
    output logic             valid_out3
);

    // One-hot port select. It is all-zero for the idle code, so that code
    // needs no special handling in the register stage.
    logic [2:0] sel;

    always_comb begin
        sel = 3'b000;
        case (control)
            2'b00:   sel = 3'b001;
            2'b01:   sel = 3'b010;
            2'b10:   sel = 3'b100;
            default: sel = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out1  <= '0;
            data_out2  <= '0;
            data_out3  <= '0;
            valid_out1 <= 1'b0;
            valid_out2 <= 1'b0;
            valid_out3 <= 1'b0;
        end else begin
            data_out1  <= sel[0] ? data_in : '0;
            data_out2  <= sel[1] ? data_in : '0;
            data_out3  <= sel[2] ? data_in : '0;
            valid_out1 <= sel[0];
            valid_out2 <= sel[1];
            valid_out3 <= sel[2];
        end
    end

endmodule

// File: tb/tb_router_1x3.sv
// tb/tb_router_1x3.sv - self-checking bench for router_1x3

module tb_router_1x3;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic [1:0] control;
    logic [7:0] data_out1;
    logic [7:0] data_out2;
    logic [7:0] data_out3;
    logic       valid_out1;
    logic       valid_out2;
    logic       valid_out3;

    int total;
    int bad;

    router_1x3 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .control    (control),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are packed as {5'b0, v3, v2, v1, d3, d2, d1}.
    localparam logic [31:0] ALL_ZERO = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {5'b0, valid_out3, valid_out2, valid_out1, data_out3, data_out2, data_out1};
    endfunction

    // Hand-written expectation: one port, or none for control 11.
    function automatic logic [31:0] route(input logic [7:0] d, input logic [1:0] c);
        logic [31:0] r;
        r = 32'h0;
        case (c)
            2'b00: begin r[7:0]   = d; r[24] = 1'b1; end
            2'b01: begin r[15:8]  = d; r[25] = 1'b1; end
            2'b10: begin r[23:16] = d; r[26] = 1'b1; end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Drive inputs, take one edge, and sample 1 ns later.
    task automatic step(input logic r, input logic [7:0] d, input logic [1:0] c);
        rst     = r;
        data_in = d;
        control = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  rd;
        logic [1:0]  rc;
        logic        rr;
        logic [31:0] exp_o;
        logic [2:0]  v;

        total = 0;
        bad   = 0;
        rst     = 1'b1;
        data_in = 8'hFF;
        control = 2'b00;

        // Reset held for two edges with port 1 selected and all-ones data.
        step(1'b1, 8'hFF, 2'b00);
        check("reset_edge1", outs(), ALL_ZERO);
        step(1'b1, 8'hFF, 2'b00);
        check("reset_edge2", outs(), ALL_ZERO);

        // Port 1 select.
        step(1'b0, 8'hAA, 2'b00);
        check("port1_sel", outs(), 32'h0100_00AA);

        // Inputs that change between edges must not reach the outputs.
        data_in = 8'h55;
        control = 2'b01;
        #3;
        check("between_edges", outs(), 32'h0100_00AA);

        // Sweep ports on consecutive edges, then go idle.
        step(1'b0, 8'hAA, 2'b01);
        check("sweep_port2", outs(), 32'h0200_AA00);
        step(1'b0, 8'hAA, 2'b10);
        check("sweep_port3", outs(), 32'h04AA_0000);
        step(1'b0, 8'hAA, 2'b11);
        check("sweep_idle", outs(), ALL_ZERO);

        // Port 3 held while the data changes every cycle, including a zero word.
        step(1'b0, 8'h01, 2'b10);
        check("p3_data_01", outs(), 32'h0401_0000);
        step(1'b0, 8'h80, 2'b10);
        check("p3_data_80", outs(), 32'h0480_0000);
        step(1'b0, 8'h00, 2'b10);
        check("p3_data_00_valid", outs(), 32'h0400_0000);

        // Mid-stream reset, then the first word after it is routed.
        step(1'b0, 8'h5A, 2'b00);
        check("mid_pre_reset", outs(), 32'h0100_005A);
        step(1'b1, 8'h5A, 2'b00);
        check("mid_reset", outs(), ALL_ZERO);
        step(1'b0, 8'h3C, 2'b01);
        check("mid_after_reset", outs(), 32'h0200_3C00);

        // Random run against the routing expectation, with occasional resets.
        for (int i = 0; i < 200; i++) begin
            rd = 8'($urandom_range(0, 255));
            rc = 2'($urandom_range(0, 3));
            rr = ($urandom_range(0, 19) == 0);
            step(rr, rd, rc);
            exp_o = rr ? ALL_ZERO : route(rd, rc);
            v = {valid_out3, valid_out2, valid_out1};
            check("rand_onehot", {31'b0, ($countones(v) <= 1)}, 32'h1);
            check("rand_route", outs(), exp_o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
